// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU bridge: default widths, FSM state
// encoding and the opcodes understood by the companion ALU.
package uart_alu_interface_pkg;

   localparam int unsigned BUS_DATOS_DEF        = 8;
   localparam int unsigned CANT_BITS_OPCODE_DEF = 6;

   typedef enum logic [2:0] {
      StEsperaA  = 3'd0,
      StEsperaB  = 3'd1,
      StEsperaOp = 3'd2,
      StCalculo  = 3'd3,
      StEnvio    = 3'd4,
      StEsperaTx = 3'd5
   } state_t;

   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_SRL = 6'h02;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_SRA = 6'h03;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_ADD = 6'h20;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_SUB = 6'h22;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_AND = 6'h24;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_OR  = 6'h25;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_XOR = 6'h26;
   localparam logic [CANT_BITS_OPCODE_DEF-1:0] ALU_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from the UART receiver, drives them to an
// external ALU, then hands the result to the UART transmitter.
module uart_alu_interface
   import uart_alu_interface_pkg::*;
#(
   parameter int unsigned BUS_DATOS        = BUS_DATOS_DEF,
   parameter int unsigned CANT_BITS_OPCODE = CANT_BITS_OPCODE_DEF
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [BUS_DATOS-1:0]        i_rx_data,
   input  logic                        i_rx_done,
   input  logic                        i_tx_done,
   input  logic [BUS_DATOS-1:0]        i_alu_result,
   output logic [BUS_DATOS-1:0]        o_alu_a,
   output logic [BUS_DATOS-1:0]        o_alu_b,
   output logic [CANT_BITS_OPCODE-1:0] o_alu_op,
   output logic [BUS_DATOS-1:0]        o_tx_data,
   output logic                        o_tx_start,
   output logic                        o_busy
);

   state_t state;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state      <= StEsperaA;
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         o_alu_op   <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         unique case (state)
            StEsperaA: begin
               if (i_rx_done) begin
                  o_alu_a <= i_rx_data;
                  state   <= StEsperaB;
               end
            end
            StEsperaB: begin
               if (i_rx_done) begin
                  o_alu_b <= i_rx_data;
                  state   <= StEsperaOp;
               end
            end
            StEsperaOp: begin
               if (i_rx_done) begin
                  o_alu_op <= i_rx_data[CANT_BITS_OPCODE-1:0];
                  o_busy   <= 1'b1;
                  state    <= StCalculo;
               end
            end
            StCalculo: begin
               // Start is raised here so it is high for exactly the ENVIO cycle.
               o_tx_data  <= i_alu_result;
               o_tx_start <= 1'b1;
               state      <= StEnvio;
            end
            StEnvio: begin
               state <= StEsperaTx;
            end
            StEsperaTx: begin
               if (i_tx_done) begin
                  o_busy <= 1'b0;
                  state  <= StEsperaA;
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= StEsperaA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed and randomized transactions through uart_alu_interface with a
// transaction-level expectation model and an ALU model beside the DUT.
module tb_uart_alu_interface;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       tx_done;
   logic [7:0] alu_result;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;
   int exp_pulses  = 0;
   logic prev_start = 1'b0;

   always #5 clock = ~clock;

   uart_alu_interface #(
      .BUS_DATOS        (8),
      .CANT_BITS_OPCODE (6)
   ) dut (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .i_tx_done    (tx_done),
      .i_alu_result (alu_result),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_busy       (busy)
   );

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         6'h02:   return a >> b;
         6'h03:   return sa >>> b;
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // o_tx_start must never stay high on two consecutive cycles.
   always @(negedge clock) begin
      if (tx_start === 1'b1) begin
         pulses++;
         chk("tx_start_width", {31'b0, prev_start}, 32'd0);
      end
      prev_start = tx_start;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      rx_data = d;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   // Idle cycles with stray tx_done pulses, which must be ignored outside ESPERA_TX.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         tx_done = 1'($urandom_range(0, 1));
         rx_data = 8'($urandom);
         tick();
      end
      tx_done = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gmax, input bit overrun, input bit simul);
      logic [7:0] res;
      int         w;
      res = alu_ref(a, b, op[5:0]);
      gap($urandom_range(0, gmax));
      send(a);
      chk("load_a", 32'(alu_a), 32'(a));
      chk("idle_busy", 32'(busy), 32'd0);
      gap($urandom_range(0, gmax));
      send(b);
      chk("load_b", 32'(alu_b), 32'(b));
      chk("hold_a", 32'(alu_a), 32'(a));
      gap($urandom_range(0, gmax));
      rx_data = op;
      rx_done = 1'b1;
      tick();
      chk("load_op", 32'(alu_op), 32'(op[5:0]));
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_start", 32'(tx_start), 32'd0);
      rx_data = 8'h77;
      rx_done = overrun;
      tick();
      rx_done = 1'b0;
      chk("envio_start", 32'(tx_start), 32'd1);
      chk("envio_data", 32'(tx_data), 32'(res));
      exp_pulses++;
      tick();
      chk("wait_start", 32'(tx_start), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      w = $urandom_range(overrun ? 1 : 0, gmax + 1);
      for (int i = 0; i < w; i++) begin
         rx_done = (overrun && i == 0);
         tick();
      end
      rx_done = 1'b0;
      chk("keep_a", 32'(alu_a), 32'(a));
      chk("keep_b", 32'(alu_b), 32'(b));
      chk("keep_op", 32'(alu_op), 32'(op[5:0]));
      chk("keep_tx_data", 32'(tx_data), 32'(res));
      tx_done = 1'b1;
      rx_done = simul;
      rx_data = 8'h77;
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      chk("done_busy", 32'(busy), 32'd0);
      chk("drop_a", 32'(alu_a), 32'(a));
   endtask

   logic [5:0] ops [8];

   initial begin
      ops = '{6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
      // Reset held with rx/tx activity: reset must win.
      reset   = 1'b0;
      rx_data = 8'hAB;
      rx_done = 1'b1;
      tx_done = 1'b1;
      repeat (3) tick();
      chk_zero("reset");
      rx_done = 1'b0;
      tx_done = 1'b0;
      reset   = 1'b1;
      tick();
      chk_zero("post_reset");

      run_txn(8'h05, 8'h03, 8'h20, 2, 1'b0, 1'b0);
      run_txn(8'hFA, 8'h0F, 8'hE4, 2, 1'b0, 1'b0);
      run_txn(8'h12, 8'h34, 8'h25, 3, 1'b1, 1'b0);
      run_txn(8'h81, 8'h02, 8'h03, 1, 1'b0, 1'b1);

      // Reset after the second operand aborts the transaction.
      send(8'h44);
      send(8'h55);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_zero("reset_mid");
      run_txn(8'h09, 8'h04, 8'h22, 1, 1'b0, 1'b0);

      // Reset while in CALCULO: no tx_start may follow.
      send(8'h10);
      send(8'h20);
      send(8'h20);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_zero("reset_calc");
      tick();
      chk("reset_calc_start", 32'(tx_start), 32'd0);
      tick();

      // Back-to-back transactions with no idle cycles.
      run_txn(8'h33, 8'h11, 8'h26, 0, 1'b0, 1'b0);
      run_txn(8'hF0, 8'h0F, 8'h27, 0, 1'b0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         run_txn(8'($urandom), 8'($urandom),
                 {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]},
                 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) tick();
      chk("pulse_count", 32'(pulses), 32'(exp_pulses));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 Parameter BUS_DATOS, default 8: width of the received/transmitted byte and of ALU operands A and B.
REQ-002 Parameter CANT_BITS_OPCODE, default 6: width of the ALU opcode; taken from the low bits of the received opcode byte.
REQ-003 One clock; reset is synchronous and active-low; port names are i_clock and i_reset.
REQ-004 i_clock  in  1  system clock; all state updates on rising edge.
REQ-005 i_reset  in  1  synchronous, active-low reset.
REQ-006 i_rx_data  in  BUS_DATOS  byte from the UART receiver; valid only while i_rx_done is high.
REQ-007 i_rx_done  in  1  one-cycle pulse: a new received byte is on i_rx_data.
REQ-008 i_tx_done  in  1  one-cycle pulse: the UART transmitter has finished sending a byte.
REQ-009 i_alu_result  in  BUS_DATOS  combinational result from the external ALU.
REQ-010 o_alu_a, o_alu_b  out  BUS_DATOS each  registered operands driven to the ALU.
REQ-011 o_alu_op  out  CANT_BITS_OPCODE  registered opcode driven to the ALU.
REQ-012 o_tx_data  out  BUS_DATOS  registered byte to send; held stable from o_tx_start until i_tx_done.
REQ-013 o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-014 o_busy  out  1  high in states CALCULO, ENVIO and ESPERA_TX.

Function
REQ-015 The FSM shall have exactly six states: ESPERA_A, ESPERA_B, ESPERA_OP, CALCULO, ENVIO, ESPERA_TX.
REQ-016 In ESPERA_A, on i_rx_done the block shall load o_alu_a with i_rx_data and move to ESPERA_B.
REQ-017 In ESPERA_B, on i_rx_done the block shall load o_alu_b with i_rx_data and move to ESPERA_OP.
REQ-018 In ESPERA_OP, on i_rx_done the block shall load o_alu_op with i_rx_data[CANT_BITS_OPCODE-1:0], discard the upper bits, and move to CALCULO.
REQ-019 CALCULO shall last exactly one cycle, then: o_tx_data <= i_alu_result; next state ENVIO.
REQ-020 ENVIO shall last exactly one cycle with o_tx_start = 1, then move to ESPERA_TX.
REQ-021 ESPERA_TX shall wait indefinitely; on i_tx_done it shall return to ESPERA_A.
REQ-022 Latency: if the opcode's i_rx_done is high in cycle N, o_alu_op is valid in N+1, o_tx_data is valid in N+2, and o_tx_start is high in N+2 only.
REQ-023 i_rx_done in CALCULO, ENVIO or ESPERA_TX shall be ignored, with no change to operands, opcode or state.
REQ-024 Simultaneous i_rx_done and i_tx_done in ESPERA_TX: the block shall return to ESPERA_A and drop the byte.
REQ-025 i_tx_done outside ESPERA_TX shall be ignored.
REQ-026 o_alu_a, o_alu_b and o_alu_op shall hold their values until overwritten in the next transaction, so the ALU output stays valid.
REQ-027 o_tx_start shall never be high for more than one consecutive cycle.

Reset
REQ-028 With i_reset = 0 at a rising edge, the block shall set: state = ESPERA_A; o_alu_a = o_alu_b = 0; o_alu_op = 0; o_tx_data = 0; o_tx_start = 0; o_busy = 0.
REQ-029 Reset in any state, including mid-transaction or in ENVIO, shall abort the transaction with no further o_tx_start pulse.
REQ-030 Reset shall have priority over i_rx_done and i_tx_done in the same cycle.

Structure
REQ-031 A shared package shall hold the state encoding constants and the default widths (BUS_DATOS = 8, CANT_BITS_OPCODE = 6); the ALU opcode constants shall live in the same package.
REQ-032 The block shall have no sub-modules: one FSM plus registers; the ALU and UART are instantiated beside it by the top.

Verification
REQ-033 Transaction: rx 0x05, 0x03, 0x20 (ADD) with a bench ALU model -> o_alu_op = 6'h20, one o_tx_start pulse with o_tx_data = 0x08, o_busy high until i_tx_done.
REQ-034 Opcode truncation: rx 0xFA, 0x0F, 0xE4 -> o_alu_op = 6'h24 (AND); o_tx_data = 0x0A.
REQ-035 Overrun: extra rx bytes 0x77 during CALCULO and ESPERA_TX -> operands unchanged, no extra o_tx_start, next transaction starts clean in ESPERA_A.
REQ-036 Reset mid-operation: reset asserted after the second operand -> all outputs 0, state ESPERA_A; the following three bytes form a complete new transaction.
REQ-037 Simultaneous i_rx_done + i_tx_done in ESPERA_TX -> state ESPERA_A, byte dropped; the next byte loads o_alu_a.
REQ-038 Back-to-back: two transactions with no idle cycles between them -> exactly two o_tx_start pulses, each with the correct result.
